uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 165 ++++++++++++++++
 tb/tb_uart_rx.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with 16x oversampling, a single-byte holding
// register with valid/ready hand-off, and frame/overrun error pulses.
module uart_rx #(
  parameter int clk_freq  = 1000000,
  parameter int baud_rate = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       busy,
  output logic [1:0] dbg_state_o
);

  localparam int DIV   = clk_freq / (baud_rate * 16);
  localparam int DIV_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  if (DIV < 2) begin : g_div_check
    $error("uart_rx: clk_freq/(baud_rate*16) must be at least 2");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             rx_s1_q, rx_s2_q, rx_prev_q;
  logic [1:0]       settle_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       tick_cnt_q, tick_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_err_q, overrun_err_d;
  logic             byte_done;
  logic             tick;
  logic             fall;

  // Oversample tick at the end of each divider period.
  assign tick = (div_q == DIV_LAST);
  // Start edge: synchronized high-to-low, ignored until the synchronizer has
  // flushed its reset value so a line held low across reset is not an edge.
  assign fall = (settle_q == 2'd3) && rx_prev_q && !rx_s2_q;

  // Two-flop synchronizer, edge-detect history and post-reset settle count.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      settle_q  <= 2'd0;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
    end
  end

  // Receiver state, timing counters and output holding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      div_q         <= '0;
      tick_cnt_q    <= 4'd0;
      bit_cnt_q     <= 3'd0;
      shift_q       <= 8'h00;
      rx_data_q     <= 8'h00;
      rx_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      tick_cnt_q    <= tick_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  // Next-state logic: frame sequencing plus the output hand-off.
  // Hand-off: rx_data is offered while rx_valid=1 and is consumed on any clock
  // where rx_valid=1 and rx_ready=1; rx_data never changes while rx_valid=1
  // except when a new byte is loaded in the very cycle the old one is taken.
  always_comb begin
    state_d       = state_q;
    div_d         = div_q;
    tick_cnt_d    = tick_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    frame_err_d   = 1'b0;
    overrun_err_d = 1'b0;
    byte_done     = 1'b0;

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    if (state_q != IDLE) begin
      div_d = tick ? '0 : div_q + 1'b1;
      if (tick) tick_cnt_d = tick_cnt_q + 4'd1;
    end

    case (state_q)
      IDLE: begin
        div_d      = '0;
        tick_cnt_d = 4'd0;
        bit_cnt_d  = 3'd0;
        if (fall) state_d = START;
      end
      START: begin
        if (tick && tick_cnt_q == 4'd7) begin
          tick_cnt_d = 4'd0;
          state_d    = rx_s2_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick && tick_cnt_q == 4'd15) begin
          shift_d   = {rx_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (tick && tick_cnt_q == 4'd15) begin
          state_d = IDLE;
          if (rx_s2_q) byte_done   = 1'b1;
          else         frame_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (byte_done) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_err_d = 1'b1;
      end
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;
  assign busy        = (state_q != IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames into uart_rx; delivered bytes are matched
// against an expected queue, error pulses and busy windows are measured.
module tb_uart_rx;

  localparam int CLK_FREQ = 1600000;
  localparam int BAUD     = 10000;
  localparam int BIT_CLKS = 160;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun_err, busy;
  logic [1:0] dbg_state;

  uart_rx #(.clk_freq(CLK_FREQ), .baud_rate(BAUD)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rx_ready   (rx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .overrun_err(overrun_err),
    .busy       (busy),
    .dbg_state_o(dbg_state)
  );

  // Clock
  always #10 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];

  int   deliveries = 0, fe_cnt = 0, fe_max = 0, ov_cnt = 0, ov_max = 0;
  int   valid_max = 0, busy_rises = 0, busy_last_len = 0;
  int   fe_run = 0, ov_run = 0, valid_run = 0, busy_run = 0;
  logic valid_prev = 1'b0, took_prev = 1'b0, busy_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    deliveries = 0; fe_cnt = 0; fe_max = 0; ov_cnt = 0; ov_max = 0;
    valid_max = 0; busy_rises = 0; busy_last_len = 0;
  endtask

  // Drivers: inputs change on the falling edge.
  task automatic drive_rx(input logic v, input int n);
    @(negedge clk);
    rx = v;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    drive_rx(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) drive_rx(b[i], BIT_CLKS);
    drive_rx(stop_bit, BIT_CLKS);
    rx = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #4;
  endtask

  task automatic consume();
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    #4;
    check("consume_valid", rx_valid, 1'b0);
  endtask

  // Scoreboard/monitor: sampled mid-low-phase, after drivers have settled.
  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      valid_prev = 1'b0; took_prev = 1'b0; busy_prev = 1'b0;
      busy_run = 0; fe_run = 0; ov_run = 0; valid_run = 0;
    end else begin
      if (rx_valid && (!valid_prev || took_prev)) begin
        deliveries++;
        if (exp_q.size() == 0) check("unexpected_byte", exp_q.size(), 1);
        else                   check("rx_data", rx_data, exp_q.pop_front());
      end
      valid_run = rx_valid ? ((valid_prev && !took_prev) ? valid_run + 1 : 1) : 0;
      if (valid_run > valid_max) valid_max = valid_run;
      fe_run = frame_err ? fe_run + 1 : 0;
      if (fe_run == 1) fe_cnt++;
      if (fe_run > fe_max) fe_max = fe_run;
      ov_run = overrun_err ? ov_run + 1 : 0;
      if (ov_run == 1) ov_cnt++;
      if (ov_run > ov_max) ov_max = ov_run;
      if (busy) begin
        if (!busy_prev) busy_rises++;
        busy_run++;
      end else begin
        if (busy_prev) busy_last_len = busy_run;
        busy_run = 0;
      end
      valid_prev = rx_valid;
      took_prev  = rx_valid && rx_ready;
      busy_prev  = busy;
    end
  end

  initial begin
    // Reset state
    rst = 1'b1; rx = 1'b1; rx_ready = 1'b0;
    idle(5);
    check("rst_valid", rx_valid, 1'b0);
    check("rst_data", rx_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_overrun_err", overrun_err, 1'b0);
    check("rst_state", dbg_state, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(20);

    // Single byte, held unconsumed
    clear_stats();
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1);
    idle(40);
    check("a5_valid", rx_valid, 1'b1);
    check("a5_data", rx_data, 8'hA5);
    check("a5_busy", busy, 1'b0);
    check("a5_busy_len", busy_last_len, 1520);
    check("a5_frame_err", fe_cnt, 0);
    check("a5_overrun", ov_cnt, 0);
    check("a5_deliveries", deliveries, 1);
    consume();

    // Start-bit glitch
    clear_stats();
    drive_rx(1'b0, 40);
    drive_rx(1'b1, 1);
    idle(200);
    check("glitch_busy_rises", busy_rises, 1);
    check("glitch_busy_len", busy_last_len, 80);
    check("glitch_busy", busy, 1'b0);
    check("glitch_valid", rx_valid, 1'b0);
    check("glitch_flags", fe_cnt + ov_cnt, 0);
    check("glitch_deliveries", deliveries, 0);

    // Stop bit low
    clear_stats();
    send_byte(8'h3C, 1'b0);
    idle(200);
    check("ferr_count", fe_cnt, 1);
    check("ferr_width", fe_max, 1);
    check("ferr_valid", rx_valid, 1'b0);
    check("ferr_deliveries", deliveries, 0);
    check("ferr_state", dbg_state, 2'd0);

    // Overrun: second byte arrives while first is held
    clear_stats();
    exp_q.push_back(8'h11);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    idle(40);
    check("ovr_data", rx_data, 8'h11);
    check("ovr_valid", rx_valid, 1'b1);
    check("ovr_count", ov_cnt, 1);
    check("ovr_width", ov_max, 1);
    check("ovr_deliveries", deliveries, 1);
    check("ovr_frame_err", fe_cnt, 0);
    consume();

    // Consumer always ready
    clear_stats();
    @(negedge clk);
    rx_ready = 1'b1;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    idle(40);
    check("rdy_deliveries", deliveries, 2);
    check("rdy_valid_width", valid_max, 1);
    check("rdy_overrun", ov_cnt, 0);
    check("rdy_valid", rx_valid, 1'b0);
    rx_ready = 1'b0;

    // Reset during data bit 3, then a clean frame
    clear_stats();
    drive_rx(1'b0, BIT_CLKS);
    drive_rx(1'b0, BIT_CLKS);
    drive_rx(1'b1, BIT_CLKS);
    drive_rx(1'b0, BIT_CLKS);
    drive_rx(1'b1, 80);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(320);
    check("abort_busy", busy, 1'b0);
    check("abort_valid", rx_valid, 1'b0);
    check("abort_data", rx_data, 8'h00);
    exp_q.push_back(8'hC3);
    send_byte(8'hC3, 1'b1);
    idle(40);
    check("c3_deliveries", deliveries, 1);
    check("c3_valid", rx_valid, 1'b1);
    check("c3_data", rx_data, 8'hC3);
    check("c3_flags", fe_cnt + ov_cnt, 0);
    check("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
